// File: rtl/pu_slave_spi_framer.sv
// RX/TX frame buffer between the PU SPI slave byte driver and the processing unit.
// Optional macro PU_SPI_FRAMER_LSB_FIRST_EN: byte 0 occupies the low bits of the frame words.
module pu_slave_spi_framer #(
  parameter int BYTE_WIDTH  = 8,
  parameter int FRAME_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cs,
  input  logic                              spi_ready,
  input  logic                              spi_prepare,
  input  logic [BYTE_WIDTH-1:0]             spi_data_out,
  output logic [BYTE_WIDTH-1:0]             spi_data_in,
  input  logic [FRAME_BYTES*BYTE_WIDTH-1:0] tx_frame,
  input  logic                              tx_load,
  output logic                              tx_pending,
  output logic [FRAME_BYTES*BYTE_WIDTH-1:0] rx_frame,
  output logic                              rx_valid,
  output logic                              rx_error
);

  localparam int FW    = FRAME_BYTES * BYTE_WIDTH;
  localparam int IDX_W = $clog2(FRAME_BYTES + 2);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(FRAME_BYTES);
  localparam logic [IDX_W-1:0] IDX_OVF  = IDX_W'(FRAME_BYTES + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic int lane(input int i);
`ifdef PU_SPI_FRAMER_LSB_FIRST_EN
    lane = i;
`else
    lane = FRAME_BYTES - 1 - i;
`endif
  endfunction

  // An index past the last byte yields zero, which the driver shifts out on overrun.
  function automatic logic [BYTE_WIDTH-1:0] get_byte(input logic [FW-1:0] frame,
                                                     input logic [IDX_W-1:0] idx);
    get_byte = {BYTE_WIDTH{1'b0}};
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (idx == IDX_W'(i)) get_byte = frame[lane(i)*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endfunction

  function automatic logic [FW-1:0] put_byte(input logic [FW-1:0] frame,
                                             input logic [IDX_W-1:0] idx,
                                             input logic [BYTE_WIDTH-1:0] b);
    put_byte = frame;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (idx == IDX_W'(i)) put_byte[lane(i)*BYTE_WIDTH +: BYTE_WIDTH] = b;
    end
  endfunction

  state_t           state_r;
  logic             cs_meta_r;
  logic             cs_sync_r;
  logic             ready_prev_r;
  logic             prepare_prev_r;
  logic [IDX_W-1:0] rx_idx_r;
  logic [IDX_W-1:0] tx_idx_r;
  logic [FW-1:0]    rx_shadow_r;
  logic [FW-1:0]    tx_active_r;
  logic [FW-1:0]    tx_pend_r;

  logic             cs_fall_s;
  logic             cs_rise_s;
  logic             ready_rise_s;
  logic             prepare_rise_s;
  logic [IDX_W-1:0] tx_idx_nxt_s;
  logic [FW-1:0]    tx_active_nxt_s;

  // Edge decode and next TX index/frame, so spi_data_in can follow one cycle after an edge.
  always_comb begin
    cs_fall_s       = (state_r == ST_IDLE) && !cs_sync_r;
    cs_rise_s       = (state_r == ST_ACTIVE) && cs_sync_r;
    ready_rise_s    = spi_ready && !ready_prev_r;
    prepare_rise_s  = (state_r == ST_ACTIVE) && spi_prepare && !prepare_prev_r;
    tx_idx_nxt_s    = tx_idx_r;
    tx_active_nxt_s = tx_active_r;
    if (cs_fall_s || cs_rise_s) begin
      tx_idx_nxt_s = {IDX_W{1'b0}};
    end else if (prepare_rise_s && (tx_idx_r != IDX_FULL)) begin
      tx_idx_nxt_s = tx_idx_r + IDX_W'(1);
    end else begin
      tx_idx_nxt_s = tx_idx_r;
    end
    if (cs_rise_s && tx_pending) begin
      tx_active_nxt_s = tx_pend_r;
    end else begin
      tx_active_nxt_s = tx_active_r;
    end
  end

  // cs synchroniser, transaction FSM, RX capture, TX buffering and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cs_meta_r      <= 1'b1;
      cs_sync_r      <= 1'b1;
      ready_prev_r   <= 1'b0;
      prepare_prev_r <= 1'b0;
      rx_idx_r       <= {IDX_W{1'b0}};
      tx_idx_r       <= {IDX_W{1'b0}};
      rx_shadow_r    <= {FW{1'b0}};
      tx_active_r    <= {FW{1'b0}};
      tx_pend_r      <= {FW{1'b0}};
      tx_pending     <= 1'b0;
      rx_frame       <= {FW{1'b0}};
      rx_valid       <= 1'b0;
      rx_error       <= 1'b0;
      spi_data_in    <= {BYTE_WIDTH{1'b0}};
    end else begin
      cs_meta_r      <= cs;
      cs_sync_r      <= cs_meta_r;
      ready_prev_r   <= spi_ready;
      prepare_prev_r <= spi_prepare;
      tx_idx_r       <= tx_idx_nxt_s;
      tx_active_r    <= tx_active_nxt_s;
      spi_data_in    <= get_byte(tx_active_nxt_s, tx_idx_nxt_s);
      rx_valid       <= 1'b0;
      rx_error       <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r  <= ST_ACTIVE;
            rx_idx_r <= {IDX_W{1'b0}};
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_s) begin
            state_r  <= ST_IDLE;
            rx_idx_r <= {IDX_W{1'b0}};
            if (rx_idx_r == IDX_FULL) begin
              rx_frame <= rx_shadow_r;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end else if (ready_rise_s) begin
            if (rx_idx_r < IDX_FULL) begin
              rx_shadow_r <= put_byte(rx_shadow_r, rx_idx_r, spi_data_out);
            end
            if (rx_idx_r != IDX_OVF) begin
              rx_idx_r <= rx_idx_r + IDX_W'(1);
            end
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // A load on the swap cycle wins: the swap already consumed the old pending frame.
      if (tx_load) begin
        tx_pend_r  <= tx_frame;
        tx_pending <= 1'b1;
      end else if (cs_rise_s) begin
        tx_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pu_slave_spi_framer.sv
// Self-checking bench for pu_slave_spi_framer: directed and randomized SPI transactions vs a frame-level model.
module tb_pu_slave_spi_framer;

  localparam int FB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        spi_ready;
  logic        spi_prepare;
  logic [7:0]  spi_data_out;
  logic [7:0]  spi_data_in;
  logic [31:0] tx_frame;
  logic        tx_load;
  logic        tx_pending;
  logic [31:0] rx_frame;
  logic        rx_valid;
  logic        rx_error;

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level reference model
  logic [31:0] m_active  = 32'h0;
  logic [31:0] m_pend    = 32'h0;
  logic [31:0] m_rx      = 32'h0;
  bit          m_pending = 1'b0;
  logic [7:0]  mosi [8];

  always #5 clk = ~clk;

  pu_slave_spi_framer #(.BYTE_WIDTH(8), .FRAME_BYTES(FB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .spi_ready   (spi_ready),
    .spi_prepare (spi_prepare),
    .spi_data_out(spi_data_out),
    .spi_data_in (spi_data_in),
    .tx_frame    (tx_frame),
    .tx_load     (tx_load),
    .tx_pending  (tx_pending),
    .rx_frame    (rx_frame),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] f, input int k);
    if (k >= FB) return 8'h00;
`ifdef PU_SPI_FRAMER_LSB_FIRST_EN
    return 8'(f >> (8 * k));
`else
    return 8'(f >> (8 * (FB - 1 - k)));
`endif
  endfunction

  function automatic logic [31:0] assemble();
    logic [31:0] acc = 32'h0;
    for (int i = 0; i < FB; i++) begin
`ifdef PU_SPI_FRAMER_LSB_FIRST_EN
      acc = acc | (32'(mosi[i]) << (8 * i));
`else
      acc = (acc << 8) | 32'(mosi[i]);
`endif
    end
    return acc;
  endfunction

  task automatic do_load(input logic [31:0] v);
    tx_frame = v;
    tx_load  = 1'b1;
    tick(1);
    tx_load  = 1'b0;
    m_pend    = v;
    m_pending = 1'b1;
    chk("tx_pending_set", 32'(tx_pending), 32'h1);
  endtask

  // One chip-select transaction of nbytes bytes, optionally with a tx_load on the swap cycle.
  task automatic run_frame(input int nbytes, input bit fixed, input bit swap_load,
                           input logic [31:0] swap_val);
    bit ok;
    cs = 1'b0;
    tick(4);
    for (int k = 0; k < nbytes; k++) begin
      chk($sformatf("miso[%0d]", k), 32'(spi_data_in), 32'(byte_of(m_active, k)));
      mosi[k]      = fixed ? 8'(17 * (k + 1)) : 8'($urandom_range(0, 255));
      spi_data_out = mosi[k];
      spi_prepare  = 1'b1;
      tick(2);
      spi_prepare  = 1'b0;
      spi_ready    = 1'b1;
      tick(1);
      spi_ready    = 1'b0;
      tick(2);
    end
    if (nbytes == FB) chk("miso_tail", 32'(spi_data_in), 32'h0);
    cs = 1'b1;
    tick(2);
    chk("no_early_pulse", 32'({rx_valid, rx_error}), 32'h0);
    if (swap_load) begin
      tx_frame = swap_val;
      tx_load  = 1'b1;
    end
    tick(1);
    tx_load = 1'b0;
    ok = (nbytes == FB);
    if (ok) m_rx = assemble();
    if (m_pending) begin
      m_active  = m_pend;
      m_pending = 1'b0;
    end
    if (swap_load) begin
      m_pend    = swap_val;
      m_pending = 1'b1;
    end
    chk("rx_valid", 32'(rx_valid), 32'(ok));
    chk("rx_error", 32'(rx_error), 32'(!ok));
    chk("rx_frame", rx_frame, m_rx);
    tick(1);
    chk("pulse_end", 32'({rx_valid, rx_error}), 32'h0);
    chk("tx_pending", 32'(tx_pending), 32'(m_pending));
    chk("miso_byte0", 32'(spi_data_in), 32'(byte_of(m_active, 0)));
    tick(2);
  endtask

  initial begin
    logic [31:0] exp_fixed;
`ifdef PU_SPI_FRAMER_LSB_FIRST_EN
    exp_fixed = 32'h44332211;
`else
    exp_fixed = 32'h11223344;
`endif
    // Reset with cs low and a tx_load strobe that must be ignored
    rst_n        = 1'b0;
    cs           = 1'b0;
    spi_ready    = 1'b0;
    spi_prepare  = 1'b0;
    spi_data_out = 8'h00;
    tx_frame     = 32'hDEADBEEF;
    tx_load      = 1'b1;
    tick(3);
    chk("rst_data_in", 32'(spi_data_in), 32'h0);
    chk("rst_rx_frame", rx_frame, 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_error", 32'(rx_error), 32'h0);
    chk("rst_tx_pending", 32'(tx_pending), 32'h0);
    rst_n   = 1'b1;
    tx_load = 1'b0;
    tick(1);
    chk("post_rst_pending", 32'(tx_pending), 32'h0);
    run_frame(4, 1'b0, 1'b0, 32'h0);

    // Load, then fixed MOSI bytes; the loaded frame appears on the following transaction
    do_load(32'hA1B2C3D4);
    run_frame(4, 1'b1, 1'b0, 32'h0);
    chk("rx_fixed", rx_frame, exp_fixed);
    run_frame(4, 1'b0, 1'b0, 32'h0);

    // Short and overlong transactions
    run_frame(3, 1'b0, 1'b0, 32'h0);
    run_frame(5, 1'b0, 1'b0, 32'h0);

    // Double load: the later frame wins, then is retransmitted
    do_load(32'h01020304);
    do_load(32'h05060708);
    run_frame(4, 1'b0, 1'b0, 32'h0);
    run_frame(4, 1'b0, 1'b0, 32'h0);
    run_frame(4, 1'b0, 1'b0, 32'h0);

    // tx_load on the exact swap cycle
    do_load(32'hCAFEF00D);
    run_frame(4, 1'b0, 1'b1, 32'h0BADBEEF);
    run_frame(4, 1'b0, 1'b0, 32'h0);
    run_frame(4, 1'b0, 1'b0, 32'h0);

    // Randomized transactions
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) do_load($urandom);
      run_frame(int'($urandom_range(2, 6)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pu_slave_spi_framer.md
# pu_slave_spi_framer

Frame buffer between the PU SPI slave byte driver and the processing unit. Collects the bytes received in one chip-select transaction into an RX frame of FRAME_BYTES bytes. Serves the bytes of a double-buffered TX frame to the driver's `data_in`, one byte per transfer. All frame swaps happen on the `cs` rising edge (end of transaction).

## Interface

Parameters:
- `BYTE_WIDTH`, default 8: width of one SPI byte; must equal the driver's DATA_WIDTH.
- `FRAME_BYTES`, default 4: bytes per frame, at least 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cs`  in  1: SPI chip select, raw pad signal, active-low.
- `spi_ready`  in  1: driver `ready`; one-cycle high pulse after each completed byte.
- `spi_prepare`  in  1: driver `prepare`; high while the last bit of a byte is shifted.
- `spi_data_out`  in  BYTE_WIDTH: driver `data_out`; byte just received.
- `spi_data_in`  out  BYTE_WIDTH: byte to the driver `data_in`; registered.
- `tx_frame`  in  FRAME_BYTES*BYTE_WIDTH: next frame to transmit.
- `tx_load`  in  1: one-cycle strobe; captures `tx_frame` into the pending register.
- `tx_pending`  out  1: a loaded frame is waiting for the next swap.
- `rx_frame`  out  FRAME_BYTES*BYTE_WIDTH: last complete received frame.
- `rx_valid`  out  1: one-cycle pulse when `rx_frame` is updated.
- `rx_error`  out  1: one-cycle pulse when a frame ends with the wrong byte count.

## Operation

- `cs` passes through a 2-FF synchroniser (`cs_s`), reset value 1. Edges are detected on `cs_s`.
- **States:**
  - IDLE: `cs_s` = 1.
  - ACTIVE: `cs_s` = 0.
  - IDLE→ACTIVE on the falling edge of `cs_s`. This clears `rx_idx` and `tx_idx` to 0.
  - ACTIVE→IDLE on the rising edge of `cs_s`. This performs the frame swap.
- **RX byte capture:** on the rising edge of `spi_ready` (registered previous value 0, current 1) while in ACTIVE:
  - If `rx_idx` < FRAME_BYTES: write `spi_data_out` to `rx_shadow[rx_idx]`.
  - `rx_idx` increments, saturating at FRAME_BYTES+1 (this value marks overflow).
  - `spi_ready` edges seen in IDLE are ignored.
- **TX byte advance:**
  - Rising edge of `spi_prepare` in ACTIVE: `tx_idx` increments, saturating at FRAME_BYTES.
  - `spi_data_in` = `tx_active[tx_idx]`, or 0 when `tx_idx` = FRAME_BYTES.
- **Frame swap** (rising edge of `cs_s`):
  - If `rx_idx` == FRAME_BYTES: `rx_frame` <= `rx_shadow`, and pulse `rx_valid`.
  - Otherwise (short frame or overflow): pulse `rx_error`; `rx_frame` is unchanged.
  - If `tx_pending`: `tx_active` <= pending register, and clear `tx_pending`. Otherwise `tx_active` is kept, so the last frame is retransmitted.
  - `rx_idx` and `tx_idx` are cleared to 0.
- **`tx_load`:**
  - Always captures `tx_frame` into the pending register and sets `tx_pending`.
  - If `tx_pending` is already set, the pending frame is overwritten.
  - `tx_load` on the swap cycle: the swap uses the old pending value; the new value stays pending and `tx_pending` stays 1.
- **Byte order:** byte 0 maps to the most significant byte of `tx_frame` and `rx_frame`.
- **Reset values:** `spi_data_in`=0, `rx_frame`=0, `rx_valid`=0, `rx_error`=0, `tx_pending`=0. `tx_active`, the pending register, `rx_shadow` and the indices are all 0.
- **Reset mid-frame:** everything returns to reset values. The `cs_s` synchroniser is forced to 1, so a still-low `cs` is seen as a new falling edge after release.

## Timing

- Cycle N: `spi_prepare` edge detected. Cycle N+1: `spi_data_in` shows the next byte. The driver reloads its preload register every cycle before its next `sclk` fall, so this latency is sufficient provided `sclk` half-period ≥ 4 `clk`.
- Cycle N: `spi_ready` rising edge. Cycle N+1: `rx_shadow` is updated.
- `cs` pad edge to `rx_valid`/`rx_error`: 3 cycles (2 synchroniser + 1 edge register).
- `spi_data_in` shows the new byte 0 one cycle after the swap.
- `tx_load` at cycle N: `tx_pending`=1 at cycle N+1.

## Configuration

- Macro: `PU_SPI_FRAMER_LSB_FIRST_EN`.
- Undefined: byte 0 is the MSB of the frame words, as described above.
- Defined: byte 0 maps to bits [BYTE_WIDTH-1:0] of both `tx_frame` and `rx_frame`, i.e. little-endian byte order. All other behaviour is identical.

## Test plan

All scenarios use BYTE_WIDTH=8, FRAME_BYTES=4.

- Reset held with `cs`=0 and `tx_load` pulsed → all outputs 0; after release, a falling edge is detected and `spi_data_in`=0x00.
- `tx_load` with 0xA1B2C3D4, then a 4-byte transaction with MOSI 0x11,0x22,0x33,0x44 → MISO sees 0xA1,0xB2,0xC3,0xD4 on the following frame. This frame: `rx_frame`=0x11223344, and `rx_valid` pulses once 3 cycles after `cs` rises.
- 3-byte transaction → `rx_error` pulses, `rx_valid` stays 0, `rx_frame` keeps its previous value. 5-byte transaction → `rx_error` pulses; the 5th byte on MISO is 0x00.
- Two `tx_load` strobes (0x01020304, then 0x05060708) before `cs` rises → the swap uses 0x05060708 and `tx_pending`=0. No further load → the next frame retransmits 0x05060708.
- `tx_load` asserted on the exact swap cycle → `tx_active` takes the old pending value; `tx_pending` remains 1 with the new value.
- With `PU_SPI_FRAMER_LSB_FIRST_EN` defined, received bytes 0x11,0x22,0x33,0x44 → `rx_frame`=0x44332211.
